// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings, FSM states
// and the alignment/legality helpers used at request acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = (off != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

    // Unsigned widths only exist for loads; 011/110/111 are never legal.
    function automatic logic illegal_f3(input logic store, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: illegal_f3 = 1'b0;
            F3_BU, F3_HU:     illegal_f3 = store;
            default:          illegal_f3 = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte/halfword lane handling: merges store data into a read word and
// extracts/extends load data from a read word.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    always_comb begin
        o_merged = i_word;
        w_byte   = 8'h00;
        w_half   = i_off[1] ? i_word[31:16] : i_word[15:0];
        w_sign   = ~i_funct3[2];
        case (i_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        if (i_funct3[0]) begin
            if (i_off[1]) o_merged[31:16] = i_wdata;
            else          o_merged[15:0]  = i_wdata;
        end else begin
            case (i_off)
                2'd0: o_merged[7:0]   = i_wdata[7:0];
                2'd1: o_merged[15:8]  = i_wdata[7:0];
                2'd2: o_merged[23:16] = i_wdata[7:0];
                default: o_merged[31:24] = i_wdata[7:0];
            endcase
        end
        case (i_funct3[1:0])
            2'b00:   o_load = {{24{w_sign & w_byte[7]}}, w_byte};
            2'b01:   o_load = {{16{w_sign & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_controller.sv
// Load/store sequencer for a word-only memory; sub-word stores become read-modify-write.
// States: IDLE accept | READ fetch word | WRITE store word | DONE response | ERR error response
module store_rmw_controller
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    state_t            r_state;
    logic              r_ready, r_mem_req, r_mem_we, r_resp_valid, r_resp_error, r_store;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata, r_resp_rdata;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [15:0]       r_wdata;
    logic [31:0]       w_merged, w_load;
    logic              w_reject, w_sw;

    assign w_reject = misaligned(req_funct3, req_addr[1:0]) || illegal_f3(req_store, req_funct3);
    assign w_sw     = req_store && (req_funct3 == F3_W);

    // Merge/extract straight from mem_rdata so the RMW write follows the read ack directly.
    lsu_lane_merge u_lane_merge (
        .i_word   (mem_rdata),
        .i_wdata  (r_wdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
            r_store      <= 1'b0;
            r_f3         <= '0;
            r_off        <= '0;
            r_wdata      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: if (req_valid && r_ready) begin
                    r_ready <= 1'b0;
                    r_store <= req_store;
                    r_f3    <= req_funct3;
                    r_off   <= req_addr[1:0];
                    r_wdata <= req_wdata[15:0];
                    if (w_reject) begin
                        r_state      <= ERR;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
                        r_state     <= w_sw ? WRITE : READ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_sw;
                        r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_wdata <= req_wdata;
                    end
                end
                READ: if (mem_ack) begin
                    if (r_store) begin
                        r_state     <= WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end else begin
                        r_state      <= DONE;
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b0;
                        r_resp_rdata <= w_load;
                    end
                end
                WRITE: if (mem_ack) begin
                    r_state      <= DONE;
                    r_mem_req    <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= '0;
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_error = r_resp_error;

endmodule

// File: tb/tb_store_rmw_controller.sv
// Scoreboard bench for store_rmw_controller: expected responses and memory
// writes are queued at issue time and checked by independent monitors.
module tb_store_rmw_controller;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk, reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, acc_cyc = 0, n_acc = 0;
    int n_req_cycles = 0, n_reads = 0, wait_cnt = 0;
    int rd_delay = 0, wr_delay = 0;

    bit [31:0] mem [bit [31:0]];
    exp_t exp_q[$];
    wr_t  wr_q[$];

    store_rmw_controller #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Memory model: ack after a programmable number of cycles with mem_req high.
    always @(negedge clk) begin
        wr_t w;
        mem_ack = 1'b0;
        if (mem_req && !reset) begin
            n_req_cycles++;
            if (wait_cnt >= (mem_we ? wr_delay : rd_delay)) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_write: got addr %h data %h required none", mem_addr, mem_wdata);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_addr", mem_addr, w.a);
                        chk("write_data", mem_wdata, w.d);
                    end
                    mem[mem_addr] = mem_wdata;
                end else begin
                    n_reads++;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                n_acc++;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_resp: got rdata %h err %b required no response", resp_rdata, resp_error);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_error", {31'b0, resp_error}, {31'b0, e.err});
                    chk("resp_latency", cyc - acc_cyc, e.lat);
                end
            end
        end
    end

    task automatic expect_resp(input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a; w.d = d;
        wr_q.push_back(w);
    endtask

    // Drives one request for a single cycle; returns 1 ns into cycle 1.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && wr_q.size() == 0 && req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_tests++; n_fail++;
            $display("FAIL timeout_%s: got %0d pending responses required 0", tag, exp_q.size());
            exp_q.delete();
            wr_q.delete();
        end
    endtask

    initial begin
        int reqs0, reads0, acc0;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_error", {31'b0, resp_error}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // SB into byte 3 via RMW
        mem[32'h100] = 32'h11223344;
        expect_write(32'h100, 32'hAB223344);
        expect_resp(32'h0, 1'b0, 3);
        issue(1'b1, 3'b000, 32'h103, 32'h123456AB);
        @(negedge clk);
        chk("sb_rd_req", {31'b0, mem_req}, 32'h1);
        chk("sb_rd_we", {31'b0, mem_we}, 32'h0);
        chk("sb_rd_addr", mem_addr, 32'h100);
        @(negedge clk);
        chk("sb_wr_we", {31'b0, mem_we}, 32'h1);
        wait_idle("sb");

        // SH upper half, then misaligned SH
        mem[32'h200] = 32'hCAFE1234;
        expect_write(32'h200, 32'hBEEF1234);
        expect_resp(32'h0, 1'b0, 3);
        issue(1'b1, 3'b001, 32'h202, 32'h0000BEEF);
        wait_idle("sh");
        reqs0 = n_req_cycles;
        expect_resp(32'h0, 1'b1, 1);
        issue(1'b1, 3'b001, 32'h201, 32'h0000BEEF);
        wait_idle("sh_mis");
        chk("sh_mis_no_mem", n_req_cycles, reqs0);

        // Other rejects: illegal load funct3, unsigned store, misaligned LW
        expect_resp(32'h0, 1'b1, 1);
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        wait_idle("ill_ld");
        expect_resp(32'h0, 1'b1, 1);
        issue(1'b1, 3'b100, 32'h100, 32'h0);
        wait_idle("ill_st");
        expect_resp(32'h0, 1'b1, 1);
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        wait_idle("lw_mis");
        chk("errors_no_mem", n_req_cycles, reqs0);

        // Loads with extension
        mem[32'h100] = 32'h00008000;
        expect_resp(32'hFFFFFF80, 1'b0, 2);
        issue(1'b0, 3'b000, 32'h101, 32'h0);
        wait_idle("lb");
        expect_resp(32'h00000080, 1'b0, 2);
        issue(1'b0, 3'b100, 32'h101, 32'h0);
        wait_idle("lbu");
        mem[32'h100] = 32'hF00D0000;
        expect_resp(32'h0000F00D, 1'b0, 2);
        issue(1'b0, 3'b101, 32'h102, 32'h0);
        wait_idle("lhu");
        expect_resp(32'hFFFFF00D, 1'b0, 2);
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        wait_idle("lh");
        expect_resp(32'hF00D0000, 1'b0, 2);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        wait_idle("lw");

        // SW with a 3-cycle ack delay
        rd_delay = 3; wr_delay = 3;
        reads0 = n_reads;
        expect_write(32'h300, 32'hDEADBEEF);
        expect_resp(32'h0, 1'b0, 5);
        issue(1'b1, 3'b010, 32'h300, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_req", {31'b0, mem_req}, 32'h1);
            chk("sw_we", {31'b0, mem_we}, 32'h1);
            chk("sw_addr", mem_addr, 32'h300);
            chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        end
        wait_idle("sw");
        chk("sw_no_read", n_reads, reads0);
        rd_delay = 0; wr_delay = 0;

        // req_valid held across an SB
        mem[32'h500] = 32'h01020304;
        expect_write(32'h500, 32'h01020377);
        expect_resp(32'h0, 1'b0, 3);
        acc0 = n_acc;
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h500; req_wdata = 32'h77;
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("hold_ready_low", {31'b0, req_ready}, 32'h0);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("hold_ready_back", {31'b0, req_ready}, 32'h1);
        wait_idle("hold");
        chk("hold_one_accept", n_acc - acc0, 1);

        // Reset during the write phase of an SB
        mem[32'h400] = 32'h55667788;
        wr_delay = 10;
        issue(1'b1, 3'b000, 32'h401, 32'h99);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_write", {31'b0, mem_we}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("abort_mem_req", {31'b0, mem_req}, 32'h0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_mem_kept", mem[32'h400], 32'h55667788);
        wr_delay = 0;
        expect_write(32'h400, 32'h55669988);
        expect_resp(32'h0, 1'b0, 3);
        issue(1'b1, 3'b000, 32'h401, 32'h99);
        wait_idle("after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion required completion");
        $fatal(1, "timeout");
    end

endmodule
